// File: rtl/csi_rx_pkt_ctrl.sv
// csi_rx_pkt_ctrl: CSI-2 packet sequencer; collects and ECC-checks the header, then streams payload and CRC.
module csi_rx_pkt_ctrl #(
  parameter bit         ECC_CORRECT_EN = 1'b1,
  parameter logic [5:0] DT_LONG_MIN    = 6'h10,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_frame,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 hdr_valid,
  output logic [1:0]           pkt_vc,
  output logic [5:0]           pkt_dt,
  output logic [15:0]          pkt_wc,
  output logic                 pkt_long,
  output logic                 ecc_corrected,
  output logic                 ecc_error,
  output logic                 pay_valid,
  output logic [7:0]           pay_data,
  output logic                 pay_last,
  output logic                 crc_valid,
  output logic [15:0]          pay_crc,
  output logic                 pkt_abort,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, SKIP} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, crc_lo_q, crc_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic wait_eot_q, wait_eot_d;
  logic hdr_valid_d, ecc_corrected_d, ecc_error_d, pay_valid_d, pay_last_d, crc_valid_d, pkt_abort_d, pkt_long_d;
  logic [1:0] pkt_vc_d;
  logic [5:0] pkt_dt_d;
  logic [15:0] pkt_wc_d, pay_crc_d;
  logic [7:0] pay_data_d;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic acc, hdr_ok;
  logic [5:0] syn;
  logic [23:0] flip, fixed;
  // Parity masks of the CSI-2 header Hamming code, one per ECC bit
  function automatic logic [5:0] ecc(input logic [23:0] d);
    ecc = {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
           ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
  assign acc = in_frame & in_valid;
  assign syn = ecc({b2_q, b1_q, b0_q}) ^ in_data[5:0];
  always_comb begin
    flip = '0;
    for (int i = 0; i < 24; i++) flip[i] = (ecc(24'd1 << i) == syn);
  end
  assign hdr_ok = (syn == 6'd0) || (ECC_CORRECT_EN && ((|flip) || $onehot(syn)));
  assign fixed  = {b2_q, b1_q, b0_q} ^ flip;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    b0_d = b0_q;
    b1_d = b1_q;
    b2_d = b2_q;
    crc_lo_d = crc_lo_q;
    cnt_d = cnt_q;
    wait_eot_d = in_frame ? wait_eot_q : 1'b0;
    hdr_valid_d = 1'b0;
    ecc_corrected_d = 1'b0;
    ecc_error_d = 1'b0;
    pay_valid_d = 1'b0;
    pay_last_d = 1'b0;
    crc_valid_d = 1'b0;
    pkt_abort_d = 1'b0;
    pay_data_d = pay_data;
    pay_crc_d = pay_crc;
    pkt_vc_d = pkt_vc;
    pkt_dt_d = pkt_dt;
    pkt_wc_d = pkt_wc;
    pkt_long_d = pkt_long;
    err_count_d = err_count;
    if ((state_q == HDR || state_q == PAYLOAD || state_q == CRC) && !in_frame) begin
      pkt_abort_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (acc && !wait_eot_q) begin
          b0_d = in_data;
          idx_d = 2'd1;
          state_d = HDR;
        end
        HDR: if (acc) begin
          idx_d = idx_q + 2'd1;
          b1_d = (idx_q == 2'd1) ? in_data : b1_q;
          b2_d = (idx_q == 2'd2) ? in_data : b2_q;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (hdr_ok) begin
              hdr_valid_d = 1'b1;
              ecc_corrected_d = (syn != 6'd0);
              pkt_vc_d = fixed[7:6];
              pkt_dt_d = fixed[5:0];
              pkt_wc_d = fixed[23:8];
              pkt_long_d = (fixed[5:0] >= DT_LONG_MIN);
              cnt_d = fixed[23:8];
              state_d = !pkt_long_d ? IDLE : (fixed[23:8] != 16'd0) ? PAYLOAD : CRC;
              wait_eot_d = !pkt_long_d;
            end else begin
              ecc_error_d = 1'b1;
              err_count_d = (&err_count) ? err_count : err_count + ERR_CNT_W'(1);
              state_d = SKIP;
            end
          end
        end
        PAYLOAD: if (acc) begin
          pay_valid_d = 1'b1;
          pay_data_d = in_data;
          cnt_d = cnt_q - 16'd1;
          pay_last_d = (cnt_q == 16'd1);
          state_d = (cnt_q == 16'd1) ? CRC : PAYLOAD;
        end
        CRC: if (acc) begin
          idx_d = 2'd1;
          crc_lo_d = in_data;
          if (idx_q != 2'd0) begin
            idx_d = 2'd0;
            pay_crc_d = {in_data, crc_lo_q};
            crc_valid_d = 1'b1;
            wait_eot_d = 1'b1;
            state_d = IDLE;
          end
        end
        SKIP: state_d = in_frame ? SKIP : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      crc_lo_q <= '0;
      cnt_q <= '0;
      wait_eot_q <= 1'b0;
      hdr_valid <= 1'b0;
      ecc_corrected <= 1'b0;
      ecc_error <= 1'b0;
      pay_valid <= 1'b0;
      pay_last <= 1'b0;
      crc_valid <= 1'b0;
      pkt_abort <= 1'b0;
      pay_data <= '0;
      pay_crc <= '0;
      pkt_vc <= '0;
      pkt_dt <= '0;
      pkt_wc <= '0;
      pkt_long <= 1'b0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      crc_lo_q <= crc_lo_d;
      cnt_q <= cnt_d;
      wait_eot_q <= wait_eot_d;
      hdr_valid <= hdr_valid_d;
      ecc_corrected <= ecc_corrected_d;
      ecc_error <= ecc_error_d;
      pay_valid <= pay_valid_d;
      pay_last <= pay_last_d;
      crc_valid <= crc_valid_d;
      pkt_abort <= pkt_abort_d;
      pay_data <= pay_data_d;
      pay_crc <= pay_crc_d;
      pkt_vc <= pkt_vc_d;
      pkt_dt <= pkt_dt_d;
      pkt_wc <= pkt_wc_d;
      pkt_long <= pkt_long_d;
      err_count <= err_count_d;
    end
  end
endmodule

// File: tb/tb_csi_rx_pkt_ctrl.sv
// tb_csi_rx_pkt_ctrl: directed checks of header decode/ECC, payload, CRC, abort, saturation and reset.
module tb_csi_rx_pkt_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_frame = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic hdr_valid, pkt_long, ecc_corrected, ecc_error, pay_valid, pay_last, crc_valid, pkt_abort;
  logic [1:0] pkt_vc;
  logic [5:0] pkt_dt;
  logic [15:0] pkt_wc, pay_crc;
  logic [7:0] pay_data, err_count;
  int tests = 0, fails = 0;
  csi_rx_pkt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_frame(in_frame), .in_valid(in_valid), .in_data(in_data),
    .hdr_valid(hdr_valid), .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc), .pkt_long(pkt_long),
    .ecc_corrected(ecc_corrected), .ecc_error(ecc_error), .pay_valid(pay_valid), .pay_data(pay_data),
    .pay_last(pay_last), .crc_valid(crc_valid), .pay_crc(pay_crc), .pkt_abort(pkt_abort),
    .err_count(err_count));
  always #5 clk = ~clk;
  task automatic cyc(input logic f, input logic v, input logic [7:0] d);
    @(negedge clk);
    in_frame = f;
    in_valid = v;
    in_data = d;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic bad_hdr();
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h19);
    cyc(0, 0, 8'h00);
  endtask
  initial begin
    repeat (3) cyc(0, 0, 8'h00);
    chk("rst_hdr_valid", 32'(hdr_valid), 0);
    chk("rst_pay_valid", 32'(pay_valid), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_pkt_wc", 32'(pkt_wc), 0);
    rst_n = 1'b1;
    cyc(0, 0, 8'h00);
    // short packet, one trailer byte while frame stays high
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h1A);
    cyc(1, 1, 8'h2B);
    chk("t1_hdr_valid", 32'(hdr_valid), 1);
    chk("t1_vc_dt", 32'({pkt_vc, pkt_dt}), 0);
    chk("t1_wc", 32'(pkt_wc), 32'h0001);
    chk("t1_long", 32'(pkt_long), 0);
    chk("t1_ecc_flags", 32'({ecc_corrected, ecc_error}), 0);
    cyc(0, 0, 8'h00);
    chk("t1_hdr_pulse", 32'(hdr_valid), 0);
    // long packet with payload, CRC and a trailer that looks like a header
    cyc(1, 1, 8'h2B); cyc(1, 1, 8'h04); cyc(1, 1, 8'h00); cyc(1, 1, 8'h34);
    cyc(1, 1, 8'h11);
    chk("t2_hdr_valid", 32'(hdr_valid), 1);
    chk("t2_dt", 32'(pkt_dt), 32'h2B);
    chk("t2_wc", 32'(pkt_wc), 32'h0004);
    chk("t2_long", 32'(pkt_long), 1);
    cyc(1, 1, 8'h22);
    chk("t2_pay0", 32'({pay_valid, pay_last, pay_data}), 32'h211);
    cyc(1, 1, 8'h33);
    chk("t2_pay1", 32'({pay_valid, pay_last, pay_data}), 32'h222);
    cyc(1, 1, 8'h44);
    chk("t2_pay2", 32'({pay_valid, pay_last, pay_data}), 32'h233);
    cyc(1, 1, 8'hAA);
    chk("t2_pay3_last", 32'({pay_valid, pay_last, pay_data}), 32'h344);
    cyc(1, 1, 8'hBB);
    chk("t2_pay_done", 32'(pay_valid), 0);
    cyc(1, 1, 8'h00);
    chk("t2_crc_valid", 32'(crc_valid), 1);
    chk("t2_crc", 32'(pay_crc), 32'hBBAA);
    cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h1A);
    cyc(0, 0, 8'h00);
    chk("t2_trailer_ignored", 32'(hdr_valid), 0);
    // single-bit data error in bit 8
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h00); cyc(1, 1, 8'h00); cyc(1, 1, 8'h1A);
    cyc(0, 0, 8'h00);
    chk("t3_hdr_valid", 32'(hdr_valid), 1);
    chk("t3_corrected", 32'(ecc_corrected), 1);
    chk("t3_wc", 32'(pkt_wc), 32'h0001);
    chk("t3_ecc_error", 32'(ecc_error), 0);
    // double-bit error: uncorrectable, rest dropped
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h19);
    cyc(1, 1, 8'h11);
    chk("t4_ecc_error", 32'(ecc_error), 1);
    chk("t4_hdr_valid", 32'(hdr_valid), 0);
    chk("t4_err_count", 32'(err_count), 1);
    cyc(1, 1, 8'h22);
    chk("t4_no_pay", 32'(pay_valid), 0);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    chk("t4_no_abort", 32'(pkt_abort), 0);
    // frame drops after two payload bytes
    cyc(1, 1, 8'h2B); cyc(1, 1, 8'h04); cyc(1, 1, 8'h00); cyc(1, 1, 8'h34);
    cyc(1, 1, 8'h11); cyc(1, 1, 8'h22);
    chk("t5_pay0", 32'({pay_valid, pay_data}), 32'h111);
    cyc(0, 0, 8'h00);
    chk("t5_pay1", 32'({pay_valid, pay_data}), 32'h122);
    cyc(0, 0, 8'h00);
    chk("t5_abort", 32'(pkt_abort), 1);
    chk("t5_abort_no_pay", 32'(pay_valid), 0);
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h1A);
    cyc(0, 0, 8'h00);
    chk("t5_next_hdr", 32'({hdr_valid, pkt_long, pkt_wc}), 32'h20001);
    chk("t5_abort_pulse", 32'(pkt_abort), 0);
    // counter saturation: 1 so far, 253 more -> FE, 5 more -> FF
    for (int i = 0; i < 253; i++) bad_hdr();
    chk("t6_err_fe", 32'(err_count), 32'hFE);
    for (int i = 0; i < 5; i++) bad_hdr();
    chk("t6_err_sat", 32'(err_count), 32'hFF);
    // asynchronous reset in the middle of a payload
    cyc(1, 1, 8'h2B); cyc(1, 1, 8'h04); cyc(1, 1, 8'h00); cyc(1, 1, 8'h34);
    cyc(1, 1, 8'h11); cyc(1, 1, 8'h22);
    chk("t6_pre_rst_pay", 32'(pay_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pay", 32'({pay_valid, pay_data}), 0);
    chk("t6_rst_err", 32'(err_count), 0);
    chk("t6_rst_fields", 32'({pkt_long, pkt_dt, pkt_wc}), 0);
    cyc(0, 0, 8'h00);
    rst_n = 1'b1;
    cyc(0, 0, 8'h00);
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h01); cyc(1, 1, 8'h00); cyc(1, 1, 8'h1A);
    cyc(0, 0, 8'h00);
    chk("t6_post_rst_hdr", 32'({hdr_valid, pkt_wc}), 32'h10001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
